// File: rtl/mem_responder.sv
// Loadable word memory: a host fills it in LOAD, then a CPU reads and writes it in RUN.
// Memory contents survive reset; only the control state and the output registers are cleared.
module mem_responder #(
   parameter int AW = 5,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_,
   input  logic [AW-1:0] addr,
   input  logic          mem_rd,
   input  logic          mem_wr,
   input  logic [DW-1:0] data_in,
   output logic [DW-1:0] data_out,
   input  logic          halt,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   input  logic          ld_last,
   output logic          ld_ready,
   output logic          cpu_en,
   output logic [AW:0]   ld_count,
   output logic          proto_err
);

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [AW:0] CNT_MAX = '1;
   localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

   state_t        state_q;
   state_t        state_d;
   logic [DW-1:0] mem [2**AW];

   logic in_load;
   logic in_run;
   logic accept_ld;
   logic cpu_rd;
   logic cpu_wr;
   logic err_event;

   assign in_load   = (state_q == LOAD);
   assign in_run    = (state_q == RUN);
   assign accept_ld = in_load && ld_valid;
   // A simultaneous read and write is served as a write only.
   assign cpu_rd    = in_run && mem_rd && !mem_wr;
   assign cpu_wr    = in_run && mem_wr;
   assign err_event = (in_load && (mem_rd || mem_wr)) || (in_run && mem_rd && mem_wr);

   assign ld_ready = in_load;
   assign cpu_en   = in_run;

   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: defaulting state_d before the case keeps this block free of inferred latches.
      state_d = state_q;
      case (state_q)
         LOAD: if (ld_valid && ld_last) state_d = RUN;
         RUN:  if (halt)                state_d = LOAD;
         default:                       state_d = LOAD;
      endcase
   end

   // NOTE: the memory array has no reset so it maps onto RAM and keeps its contents across rst_.
   always_ff @(posedge clk) begin
      if (accept_ld) begin
         mem[ld_addr] <= ld_data;
      end else if (cpu_wr) begin
         mem[addr] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         data_out  <= '0;
         ld_count  <= '0;
         proto_err <= 1'b0;
      end else begin
         if (cpu_rd) begin
            data_out <= mem[addr];
         end

         // Halt clears the count; a strobe in the same cycle is still served above.
         if (in_run && halt) begin
            ld_count <= '0;
         end else if (accept_ld && ld_count != CNT_MAX) begin
            ld_count <= ld_count + CNT_ONE;
         end

         if (err_event) begin
            proto_err <= 1'b1;
         end
      end
   end

`ifndef SYNTHESIS
   halt_returns_to_load: assert property (
      @(posedge clk) disable iff (!rst_)
      (cpu_en && halt) |=> (ld_ready && !cpu_en && ld_count == '0)
   );
`endif

endmodule
